// File: rtl/branch_unit_if.sv
// branch_unit_if: decoder/ALU side of the branch unit.
//   master : decoder/ALU/fetch side. Drives flags, flags_pend, pc_en,
//            br_req, br_cond and br_target. Observes br_ready, pc,
//            br_done, br_taken and br_err.
//   slave  : branch_unit. Mirror of the master modport.
interface branch_unit_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       flags;       // [3]=O [2]=C [1]=N [0]=Z
  logic             flags_pend;  // ALU op with unwritten flags in flight
  logic             pc_en;       // fetch strobe
  logic             br_req;
  logic [3:0]       br_cond;
  logic [WIDTH-1:0] br_target;
  logic             br_ready;
  logic [WIDTH-1:0] pc;
  logic             br_done;
  logic             br_taken;
  logic             br_err;

  modport master (
    output flags, flags_pend, pc_en, br_req, br_cond, br_target,
    input  br_ready, pc, br_done, br_taken, br_err
  );

  modport slave (
    input  flags, flags_pend, pc_en, br_req, br_cond, br_target,
    output br_ready, pc, br_done, br_taken, br_err
  );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: owns the tiny16 PC. It advances the PC on fetch strobes.
// It accepts conditional branches, waits for in-flight ALU flags, then
// redirects the PC or leaves it unchanged.
//   clk, rst : clock (rising edge) and async active-high reset
//   bus      : branch_unit_if.slave (flags, fetch strobe, branch handshake,
//              pc and the resolve pulses br_done/br_taken/br_err)
module branch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 16   // 2..255
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_e;

  localparam logic [3:0] COND_AL  = 4'd0;
  localparam logic [3:0] COND_NV  = 4'd15;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [3:0]       cond_q, cond_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic             err_q, err_d;
  logic             cond_true;

  // Condition evaluation against live flags; only consumed in RESOLVE.
  always_comb begin
    logic o, c, n, z;
    {o, c, n, z} = bus.flags;
    cond_true = 1'b0;
    case (cond_q)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = z;
      4'd2:  cond_true = ~z;
      4'd3:  cond_true = c;
      4'd4:  cond_true = ~c;
      4'd5:  cond_true = n;
      4'd6:  cond_true = ~n;
      4'd7:  cond_true = o;
      4'd8:  cond_true = ~o;
      4'd9:  cond_true = c & ~z;
      4'd10: cond_true = ~c | z;
      4'd11: cond_true = (n == o);
      4'd12: cond_true = (n != o);
      4'd13: cond_true = ~z & (n == o);
      4'd14: cond_true = z | (n != o);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cond_d  = cond_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    taken_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pc_en) pc_d = pc_q + WIDTH'(1);
        if (bus.br_req) begin
          cond_d = bus.br_cond;
          tgt_d  = bus.br_target;
          cnt_d  = '0;
          // AL/NV do not depend on flags, so they never need to wait.
          if (!bus.flags_pend || bus.br_cond == COND_AL || bus.br_cond == COND_NV)
            state_d = S_RESOLVE;
          else
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (!bus.flags_pend) begin
          state_d = S_RESOLVE;
        end else if (cnt_q == TMO_LAST) begin
          // Flags never arrived: drop the branch, PC stays put.
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_RESOLVE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (cond_true) begin
          pc_d    = tgt_q;
          taken_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cond_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign bus.br_ready = (state_q == S_IDLE);
  assign bus.pc       = pc_q;
  assign bus.br_done  = done_q;
  assign bus.br_taken = taken_q;
  assign bus.br_err   = err_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: scoreboard bench for branch_unit. Each branch request
// pushes its expected outcome. A negedge monitor pops the entry on br_done
// and compares it.
module tb_branch_unit;
  localparam int TMO = 16;

  typedef struct {
    logic        taken;
    logic        err;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_pc = 16'h0000;
  exp_t        sb_q[$];

  branch_unit_if #(.WIDTH(16)) bif ();

  branch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Reference condition table: codes pair up as (true-sense, inverse).
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic o, cy, n, z, base;
    int   k;
    {o, cy, n, z} = f;
    if (c == 4'd0)  return 1'b1;
    if (c == 4'd15) return 1'b0;
    k = (int'(c) + 1) / 2;
    case (k)
      1: base = z;
      2: base = cy;
      3: base = n;
      4: base = o;
      5: base = cy & ~z;
      6: base = (n == o);
      default: base = ~z & (n == o);
    endcase
    return c[0] ? base : ~base;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bif.br_taken && bif.br_err) chk("taken_err_both", 1, 0);
      if (!bif.br_done && (bif.br_taken || bif.br_err)) chk("pulse_without_done", 1, 0);
      if (bif.br_done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("br_taken", bif.br_taken, e.taken);
          chk("br_err", bif.br_err, e.err);
          chk("pc_at_done", bif.pc, e.pc);
        end
      end
    end
  end

  // stall = WAIT cycles with flags_pend held high after the accept edge.
  task automatic branch(input logic [3:0] c, input logic [15:0] tgt,
                        input logic [3:0] f, input int stall, input logic en);
    exp_t        e;
    int          eff;
    int          n;
    logic [15:0] base_pc;
    eff     = (c == 4'd0 || c == 4'd15) ? 0 : stall;
    base_pc = en ? model_pc + 16'd1 : model_pc;
    if (eff >= TMO) begin
      e.taken = 1'b0; e.err = 1'b1; e.pc = base_pc;
    end else begin
      e.taken = cond_ref(c, f); e.err = 1'b0;
      e.pc    = e.taken ? tgt : base_pc;
    end
    sb_q.push_back(e);
    bif.br_req     = 1'b1;
    bif.br_cond    = c;
    bif.br_target  = tgt;
    bif.flags      = ~f;           // wrong flags at accept must not matter
    bif.flags_pend = (stall > 0);
    bif.pc_en      = en;
    tick();
    bif.br_req = 1'b0;
    bif.flags  = f;
    if (eff == 0) begin
      bif.flags_pend = 1'b0;
      chk("lat_ready", bif.br_ready, 0);
      chk("lat_done", bif.br_done, 0);
      tick();
      chk("lat_resolve", sb_q.size(), 0);
    end else begin
      for (int i = 0; i < eff && i < TMO; i++) begin
        chk("wait_ready", bif.br_ready, 0);
        tick();
      end
      bif.flags_pend = 1'b0;
    end
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_seen", 0, 1);
      sb_q.delete();
    end
    chk("ready_after", bif.br_ready, 1);
    bif.pc_en = 1'b0;
    model_pc  = e.pc;
  endtask

  initial begin
    bif.flags = 4'h0; bif.flags_pend = 1'b0; bif.pc_en = 1'b0;
    bif.br_req = 1'b0; bif.br_cond = 4'h0; bif.br_target = 16'h0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_pc", bif.pc, 16'h0000);
    chk("rst_ready", bif.br_ready, 1);
    chk("rst_done", bif.br_done, 0);
    chk("rst_taken", bif.br_taken, 0);
    chk("rst_err", bif.br_err, 0);
    rst = 1'b0;
    tick();

    // fetch strobes
    bif.pc_en = 1'b1;
    tick(); tick(); tick();
    bif.pc_en = 1'b0;
    chk("pc_inc3", bif.pc, 16'h0003);
    model_pc = 16'h0003;

    // wrap 0xFFFF -> 0x0000
    branch(4'd0, 16'hFFFF, 4'h0, 0, 1'b0);
    bif.pc_en = 1'b1;
    tick();
    bif.pc_en = 1'b0;
    chk("pc_wrap", bif.pc, 16'h0000);
    model_pc = 16'h0000;

    branch(4'd1, 16'h1234, 4'b0001, 0, 1'b0);   // EQ taken
    branch(4'd0, 16'h0010, 4'h0, 0, 1'b0);      // set pc 0x0010
    branch(4'd1, 16'h1234, 4'b0000, 0, 1'b0);   // EQ not taken
    chk("eq_nt_pc", bif.pc, 16'h0010);
    branch(4'd12, 16'h0400, 4'b1000, 5, 1'b0);  // LT after 5 stall cycles
    chk("lt_pc", bif.pc, 16'h0400);
    branch(4'd2, 16'h7777, 4'b0000, 20, 1'b0);  // NE, timeout
    chk("tmo_pc", bif.pc, 16'h0400);
    branch(4'd0, 16'h2222, 4'h0, 5, 1'b0);      // AL ignores pend
    branch(4'd15, 16'h3333, 4'hF, 5, 1'b0);     // NV never taken
    branch(4'd15, 16'h3333, 4'h0, 0, 1'b1);     // pc_en honoured at accept
    branch(4'd3, 16'h4444, 4'b0100, 0, 1'b1);   // CS taken, pc_en ignored
    branch(4'd9, 16'h5555, 4'b0101, 15, 1'b1);  // HI false, longest legal wait

    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        branch(4'(c), 16'($urandom), 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    // reset mid-WAIT
    branch(4'd0, 16'h5A5A, 4'h0, 0, 1'b0);
    bif.br_req = 1'b1; bif.br_cond = 4'd1; bif.br_target = 16'h9999;
    bif.flags_pend = 1'b1;
    tick();
    bif.br_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_pc", bif.pc, 16'h0000);
    chk("rstw_ready", bif.br_ready, 1);
    chk("rstw_done", bif.br_done, 0);
    tick();
    rst = 1'b0; bif.flags_pend = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstw_pc_hold", bif.pc, 16'h0000);
    model_pc = 16'h0000;

    // reset mid-RESOLVE
    branch(4'd0, 16'h1111, 4'h0, 0, 1'b0);
    bif.br_req = 1'b1; bif.br_cond = 4'd1; bif.br_target = 16'h8888;
    bif.flags = 4'b0001;
    tick();
    bif.br_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstr_pc", bif.pc, 16'h0000);
    chk("rstr_ready", bif.br_ready, 1);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rstr_pc_hold", bif.pc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Consumer of the ALU condition flags (O C N Z). Accepts a conditional-branch request from the decoder and waits until any in-flight ALU operation has written its flags. It then evaluates the 4-bit condition code and either redirects the program counter to the branch target or leaves it unchanged. It owns the PC register for the tiny16 core and advances it on fetch strobes between branches.

Parameters:
WIDTH, 16, PC / target width in bits
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 16, max cycles spent in WAIT before abandoning the branch; legal range 2..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flags  input  4  ALU flags: [3]=O overflow, [2]=C carry, [1]=N negative, [0]=Z zero
flags_pend  input  1  high while an ALU op whose flags are not yet written is in flight
pc_en  input  1  advance PC by 1 (fetch strobe)
br_req  input  1  branch request; accepted when br_ready is high
br_cond  input  4  condition code, sampled on accept
br_target  input  WIDTH  branch destination, sampled on accept
br_ready  output  1  high only in IDLE; combinational from state
pc  output  WIDTH  current program counter, registered
br_done  output  1  one-cycle pulse: branch resolved
br_taken  output  1  one-cycle pulse with br_done: condition true, PC redirected
br_err  output  1  one-cycle pulse with br_done: WAIT timed out, branch dropped

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, br_done=br_taken=br_err=0, wait counter=0, latched cond/target=0.
- Condition codes:
  - 0 AL: always true. 1 EQ: Z. 2 NE: !Z. 3 CS: C. 4 CC: !C.
  - 5 MI: N. 6 PL: !N. 7 VS: O. 8 VC: !O.
  - 9 HI: C&!Z. 10 LS: !C|Z.
  - 11 GE: N==O. 12 LT: N!=O. 13 GT: !Z&(N==O). 14 LE: Z|(N!=O).
  - 15 NV: never true.
- IDLE:
  - pc_en=1 gives pc<=pc+1, wrapping 0xFFFF to 0x0000 (modulo 2^WIDTH).
  - br_req=1: latch br_cond and br_target.
  - Next state is RESOLVE if flags_pend=0 or br_cond is AL/NV; otherwise WAIT, with the counter cleared.
  - pc_en is still honoured in the accept cycle.
- WAIT:
  - pc_en and br_req are ignored.
  - The counter increments every cycle.
  - flags_pend=0 moves the block to RESOLVE.
  - If flags_pend is still 1 when the counter reaches TIMEOUT-1, return to IDLE. The next cycle has br_done=1, br_err=1, br_taken=0, and pc is unchanged.
- RESOLVE:
  - pc_en and br_req are ignored.
  - Evaluate the latched condition against the current flags.
  - True: pc<=latched target, br_taken=1. False: pc unchanged.
  - br_done=1 in the following cycle; state returns to IDLE.
- Latency: with flags_pend=0 at the accept edge T, RESOLVE is active in cycle T+1. The pc update and br_done/br_taken are visible after edge T+2, and br_ready returns at the same point.
- br_done, br_taken and br_err are high for exactly one cycle. br_taken and br_err are never both 1.
- A new br_req in the IDLE cycle where br_done is high is accepted normally (back-to-back branches).
- flags are sampled only in RESOLVE. Changes to flags while in IDLE or WAIT have no effect.
- Reset asserted mid-WAIT or mid-RESOLVE aborts the branch immediately. No br_done pulse follows.

Test Plan:
- Reset, then pc_en held for 3 cycles -> pc 0x0000→0x0003. Preload pc=0xFFFF, one pc_en -> pc=0x0000.
- flags=4'b0001 (Z), flags_pend=0, br_req with cond=EQ, target=0x1234 -> two edges later pc=0x1234, br_done=1, br_taken=1, br_err=0.
- flags=4'b0000, cond=EQ, target=0x1234, pc=0x0010 -> br_done=1, br_taken=0, pc stays 0x0010.
- flags_pend=1 for 5 cycles, then flags=4'b1000 (O, N=0) with pend=0, cond=LT, target=0x0400 -> stays in WAIT (br_ready=0) for 5 cycles, then taken, pc=0x0400.
- TIMEOUT=16, flags_pend stuck at 1, cond=NE -> after 16 cycles br_done=1, br_err=1, br_taken=0, pc unchanged, br_ready=1.
- In WAIT, assert rst -> pc=RESET_PC, br_ready=1 with no br_done. Separately, cond=AL with flags_pend=1 -> resolves without waiting and is taken. cond=NV -> br_done=1, br_taken=0.
